multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Datapath for the multi-cycle MIPS core. It holds the PC, the instruction register (IR), the memory data register (MDR), the A/B operand latches, ALUOut, the 32×32 register file and the ALU. It executes the per-cycle control word issued by the control unit and returns `op`, `funct` and `zero` to it. A single unified memory sits outside the block, on the `adr`/`writedata`/`readdata` interface.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `pcen`  in  1  PC write enable
- `irwrite`  in  1  IR write enable
- `regwrite`  in  1  register-file write enable
- `alusrca`  in  1  ALU A select: 0 PC, 1 A latch
- `iord`  in  1  address select: 0 PC, 1 ALUOut
- `memtoreg`  in  1  write-data select: 0 ALUOut, 1 MDR
- `regdst`  in  1  destination select: 0 rt (IR[20:16]), 1 rd (IR[15:11])
- `alusrcb`  in  2  ALU B select: 00 B latch, 01 constant 4, 10 signimm, 11 signimm<<2
- `pcsrc`  in  2  next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target, 11 ALUResult
- `alucontrol`  in  3  ALU operation
- `readdata`  in  32  memory read data
- `adr`  out  32  memory address
- `writedata`  out  32  memory write data (= B latch)
- `op`  out  6  IR[31:26]
- `funct`  out  6  IR[5:0]
- `zero`  out  1  ALUResult == 0

## Operation
- signimm = {{16{IR[15]}}, IR[15:0]}.
- Jump target = {PC[31:28], IR[25:0], 2'b00}.
- ALU codes:
  - 010 add, 110 sub, 000 and, 001 or
  - 111 slt: signed compare, result 1/0
  - 011, 100, 101 produce 0
- ALU arithmetic wraps modulo 2^32. No overflow flag.
- Register file:
  - Two combinational read ports, addressed by IR[25:21] and IR[20:16].
  - One write port: address per `regdst`, data per `memtoreg`.
  - Register 0 always reads 0. Writes to it are discarded.
- `adr` is combinational from `iord`. `op`, `funct` and `zero` are combinational from current state.
- All muxes are combinational. Only the registers listed under Timing hold state.

## Timing
- Enabled registers: PC loads on an edge only when `pcen`=1; IR loads `readdata` only when `irwrite`=1.
- Unconditional registers (load every edge): MDR←`readdata`, A←rd1, B←rd2, ALUOut←ALUResult.
- Register-file write occurs on the edge when `regwrite`=1.
- Read during write in the same cycle returns the old value. The new value is visible the following cycle.
- `irwrite` and `regwrite` in the same cycle: the write address and data use the pre-edge IR.
- Reset, evaluated at the edge and taking priority over all enables:
  - PC←`RESET_PC`.
  - IR, MDR, A, B, ALUOut and all 32 registers ← 0.
- Outputs in the cycle after reset:
  - `adr`=`RESET_PC` when `iord`=0
  - `op`=0, `funct`=0, `writedata`=0
  - `zero` follows the ALU inputs
- Reset asserted mid-instruction discards all in-flight latch contents. No partial register write completes on a reset edge.
- Latency:
  - ALU result is visible on `zero` combinationally.
  - The result is available in ALUOut one cycle later.
  - Memory data is available in MDR one cycle after `readdata`.

## Structure
- Shared package `mips_pkg`:
  - ALU code constants (`ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`)
  - `alusrcb` encodings
  - `pcsrc` encodings
  - opcode/funct field widths
- Sub-module `regfile`:
  - 32×32, two read ports, one write port, synchronous clear on `reset`, r0 hardwired to 0.
- ALU, muxes, sign-extend and pipeline latches are written inline in `multicycle_datapath`.

## Test plan
- **Reset:** pulse `reset` with `RESET_PC`=0 → `adr`=0, `op`=0, `funct`=0, `writedata`=0. All registers read 0.
- **Fetch:**
  - Stimulus: `readdata`=32'h2008_0005, `irwrite`=1, `alusrca`=0, `alusrcb`=01, `alucontrol`=010, `pcsrc`=00, `pcen`=1.
  - Response: PC=4, `op`=6'h08.
  - Then `alusrca`=1, `alusrcb`=10, followed by `regdst`=0, `memtoreg`=0, `regwrite`=1 → $8 reads 5.
- **R-type sub/slt:**
  - Setup: $8=5, $9=7.
  - IR=32'h0109_5022 (sub $10,$8,$9) → $10=32'hFFFF_FFFE, `zero`=0.
  - slt → 1.
- **Branch compare:** equal operands with `alucontrol`=110 → `zero`=1. Next, `alusrcb`=11 yields PC + (signimm<<2) in ALUOut.
- **Jump:** PC=32'h1000_0004, IR[25:0]=26'h000_0040, `pcsrc`=10, `pcen`=1 → PC=32'h1000_0100.
- **Edge cases:**
  - `regwrite` to r0 with data 32'hDEAD_BEEF → r0 still reads 0.
  - `reset` asserted during a cycle with `regwrite`=1 → target register is 0 after the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: ALU codes, mux encodings, instruction layout.
package mips_pkg;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int OP_W    = 6;
  localparam int FUNCT_W = 6;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;
  localparam logic [1:0] PCSRC_ALU_ALT = 2'b11;

  // R-type field view; I- and J-type fields are slices of the same 32 bits.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic [4:0]         shamt;
    logic [FUNCT_W-1:0] funct;
  } instr_t;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational read ports, one write port; r0 hardwired to zero.
// Reads return the pre-edge value during a write; reset clears every entry and blocks the write.
module regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, register file and ALU under an external control word.
// ALU result on zero combinationally, in ALUOut next edge; no backpressure, control unit sequences every cycle.
module multicycle_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pcen,
  input  logic               irwrite,
  input  logic               regwrite,
  input  logic               alusrca,
  input  logic               iord,
  input  logic               memtoreg,
  input  logic               regdst,
  input  logic [1:0]         alusrcb,
  input  logic [1:0]         pcsrc,
  input  logic [2:0]         alucontrol,
  input  logic [DATA_W-1:0]  readdata,
  output logic [DATA_W-1:0]  adr,
  output logic [DATA_W-1:0]  writedata,
  output logic [OP_W-1:0]    op,
  output logic [FUNCT_W-1:0] funct,
  output logic               zero
);

  logic [DATA_W-1:0] pc;
  instr_t            ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] aluout;

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] signimm;
  logic [DATA_W-1:0] srca;
  logic [DATA_W-1:0] srcb;
  logic [DATA_W-1:0] aluresult;
  logic [DATA_W-1:0] pcnext;
  logic [DATA_W-1:0] jump_target;
  logic [REG_AW-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign signimm     = sign_ext({ir.rd, ir.shamt, ir.funct});
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};

  // Write port is driven from pre-edge IR/MDR/ALUOut, so an IR load in the same cycle cannot redirect it.
  assign wa = regdst ? ir.rd : ir.rt;
  assign wd = memtoreg ? mdr : aluout;

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (ir.rs),
    .ra2   (ir.rt),
    .wa    (wa),
    .wd    (wd),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  always_comb begin
    srca = alusrca ? a_q : pc;
    srcb = b_q;
    case (alusrcb)
      SRCB_B:      srcb = b_q;
      SRCB_FOUR:   srcb = 32'd4;
      SRCB_IMM:    srcb = signimm;
      SRCB_IMM_SH: srcb = {signimm[DATA_W-3:0], 2'b00};
      default:     srcb = b_q;
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucontrol)
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_SLT: aluresult = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default: aluresult = '0;
    endcase
  end

  always_comb begin
    pcnext = aluresult;
    case (pcsrc)
      PCSRC_ALU:     pcnext = aluresult;
      PCSRC_ALUOUT:  pcnext = aluout;
      PCSRC_JUMP:    pcnext = jump_target;
      PCSRC_ALU_ALT: pcnext = aluresult;
      default:       pcnext = aluresult;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      aluout <= '0;
    end else begin
      if (pcen) begin
        pc <= pcnext;
      end
      if (irwrite) begin
        ir <= instr_t'(readdata);
      end
      mdr    <= readdata;
      a_q    <= rd1;
      b_q    <= rd2;
      aluout <= aluresult;
    end
  end

  assign adr       = iord ? aluout : pc;
  assign writedata = b_q;
  assign op        = ir.op;
  assign funct     = ir.funct;
  assign zero      = (aluresult == '0);

endmodule

// File: tb/tb_multicycle_datapath.sv
// Scoreboard bench: directed instruction sequences then random control words, checked against an architectural model.
module tb_multicycle_datapath;

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alu;
  } ctrl_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
  } exp_t;

  typedef struct {
    int          id;
    int          fld;
    logic [31:0] val;
    string       tag;
  } dir_t;

  localparam int F_ADR = 0, F_WD = 1, F_OP = 2, F_FUNCT = 3, F_ZERO = 4;

  logic        clk = 1'b0;
  logic        reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0]  alusrcb, pcsrc;
  logic [2:0]  alucontrol;
  logic [31:0] readdata;
  logic [31:0] adr, writedata;
  logic [5:0]  op, funct;
  logic        zero;

  multicycle_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
    .adr(adr), .writedata(writedata), .op(op), .funct(funct), .zero(zero)
  );

  always #5 clk = ~clk;

  // Architectural model state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  exp_t sb[$];
  dir_t dq[$];
  int   nxt_id = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [31:0] alu_ref(input logic [2:0] code, input logic [31:0] x, input logic [31:0] y);
    case (code)
      3'b010: return x + y;
      3'b110: return x - y;
      3'b000: return x & y;
      3'b001: return x | y;
      3'b111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic ctrl_t cw(input logic pe, input logic irw, input logic rw, input logic sa,
                               input logic io, input logic m2r, input logic rdst,
                               input logic [1:0] sb_sel, input logic [1:0] ps, input logic [2:0] al);
    ctrl_t c;
    c = '{pcen: pe, irwrite: irw, regwrite: rw, alusrca: sa, iord: io, memtoreg: m2r,
          regdst: rdst, alusrcb: sb_sel, pcsrc: ps, alu: al};
    return c;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void want(input int fld, input logic [31:0] val, input string tag);
    dir_t d;
    d.id = nxt_id; d.fld = fld; d.val = val; d.tag = tag;
    dq.push_back(d);
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endfunction

  // Apply one control word for one cycle: record expected outputs, then advance the model across the edge.
  task automatic step(input ctrl_t c, input logic [31:0] rd, input logic rst = 1'b0);
    logic [31:0] simm, sa, sbv, res, npc;
    logic [4:0]  wa;
    exp_t        e;
    reset = rst; pcen = c.pcen; irwrite = c.irwrite; regwrite = c.regwrite;
    alusrca = c.alusrca; iord = c.iord; memtoreg = c.memtoreg; regdst = c.regdst;
    alusrcb = c.alusrcb; pcsrc = c.pcsrc; alucontrol = c.alu; readdata = rd;

    simm = {{16{m_ir[15]}}, m_ir[15:0]};
    sa   = c.alusrca ? m_a : m_pc;
    case (c.alusrcb)
      2'b00: sbv = m_b;
      2'b01: sbv = 32'd4;
      2'b10: sbv = simm;
      default: sbv = simm * 4;
    endcase
    res = alu_ref(c.alu, sa, sbv);
    e.adr = c.iord ? m_aluout : m_pc;
    e.wd = m_b; e.op = m_ir[31:26]; e.funct = m_ir[5:0]; e.zero = (res == 0);
    sb.push_back(e);
    nxt_id++;

    case (c.pcsrc)
      2'b01: npc = m_aluout;
      2'b10: npc = {m_pc[31:28], m_ir[25:0], 2'b00};
      default: npc = res;
    endcase
    wa = c.regdst ? m_ir[15:11] : m_ir[20:16];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_a = m_rf[m_ir[25:21]];
      m_b = m_rf[m_ir[20:16]];
      if (c.regwrite && wa != 0) m_rf[wa] = c.memtoreg ? m_mdr : m_aluout;
      if (c.pcen) m_pc = npc;
      if (c.irwrite) m_ir = rd;
      m_mdr = rd;
      m_aluout = res;
    end
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr);
    step(cw(1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010), instr);
  endtask

  task automatic idle(input logic [31:0] rd = 32'h0);
    step(cw(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), rd);
  endtask

  function automatic logic [31:0] field(input int fld);
    case (fld)
      F_ADR:   return adr;
      F_WD:    return writedata;
      F_OP:    return {26'd0, op};
      F_FUNCT: return {26'd0, funct};
      default: return {31'd0, zero};
    endcase
  endfunction

  // Monitor: pops one expectation per cycle and checks it plus any directed checks tied to that cycle.
  initial begin
    int   mid;
    exp_t e;
    dir_t d;
    mid = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("adr", adr, e.adr);
        check("writedata", writedata, e.wd);
        check("op", {26'd0, op}, {26'd0, e.op});
        check("funct", {26'd0, funct}, {26'd0, e.funct});
        check("zero", {31'd0, zero}, {31'd0, e.zero});
        while (dq.size() > 0 && dq[0].id == mid) begin
          d = dq.pop_front();
          check(d.tag, field(d.fld), d.val);
        end
        mid++;
      end
    end
  end

  initial begin
    ctrl_t rc;
    int    guard;
    reset = 1; pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0;
    memtoreg = 0; regdst = 0; alusrcb = 0; pcsrc = 0; alucontrol = 0; readdata = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and fetch of addi $8,$0,5
    want(F_ADR, 32'h0, "rst_adr"); want(F_OP, 32'h0, "rst_op");
    want(F_FUNCT, 32'h0, "rst_funct"); want(F_WD, 32'h0, "rst_wd");
    fetch(32'h2008_0005);
    want(F_OP, 32'h08, "fetch_op"); want(F_ADR, 32'h4, "fetch_pc");
    step(cw(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010), 0);
    step(cw(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), 0);
    // B latched during the write cycle still holds the old $8
    want(F_WD, 32'h0, "rdw_old");
    fetch(32'h2009_0007);
    want(F_WD, 32'h5, "r8_val");
    step(cw(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 3'b010), 0);
    step(cw(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), 0);

    // sub $10,$8,$9 then slt on the same operands
    fetch(32'h0109_5022);
    idle();
    want(F_FUNCT, 32'h22, "sub_funct"); want(F_WD, 32'h7, "r9_val"); want(F_ZERO, 32'h0, "sub_zero");
    step(cw(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b110), 0);
    want(F_ADR, 32'hFFFF_FFFE, "sub_res");
    step(cw(0, 0, 1, 0, 1, 0, 1, 2'b00, 2'b00, 3'b010), 0);
    want(F_ZERO, 32'h0, "slt_zero");
    step(cw(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b111), 0);
    want(F_ADR, 32'h1, "slt_res");
    step(cw(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010), 0);
    fetch(32'h000A_0000);
    idle();
    want(F_WD, 32'hFFFF_FFFE, "r10_val");
    idle();

    // beq $8,$8,3 at PC 16: compare, then branch target PC(20)+12
    fetch(32'h1108_0003);
    idle();
    want(F_ZERO, 32'h1, "beq_zero");
    step(cw(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b110), 0);
    step(cw(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010), 0);
    want(F_ADR, 32'd32, "br_target");
    step(cw(0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010), 0);

    // Load PC=0x1000_0004 through MDR -> $8 -> A, then jump
    idle(32'h1000_0004);
    step(cw(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010), 0);
    idle();
    step(cw(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b001), 0);
    want(F_ADR, 32'h1000_0004, "pc_load");
    step(cw(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), 32'h0800_0040);
    step(cw(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010), 0);
    want(F_ADR, 32'h1000_0100, "jump_pc"); want(F_OP, 32'h02, "jump_op");
    idle();

    // Writes of 0xDEADBEEF to r0 via rt and rd are discarded
    step(cw(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), 32'h0);
    idle(32'hDEAD_BEEF);
    step(cw(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010), 32'hDEAD_BEEF);
    step(cw(0, 0, 1, 0, 0, 1, 1, 2'b00, 2'b00, 3'b010), 32'hDEAD_BEEF);
    idle();
    want(F_WD, 32'h0, "r0_zero");
    idle();

    // Reset on the same edge as a write to $12
    step(cw(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010), 32'h000C_0000);
    idle(32'h1234_5678);
    step(cw(0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 3'b010), 32'h1234_5678, 1'b1);
    want(F_ADR, 32'h0, "rst2_adr"); want(F_OP, 32'h0, "rst2_op"); want(F_WD, 32'h0, "rst2_wd");
    fetch(32'h000C_0000);
    idle();
    want(F_WD, 32'h0, "rst_wr_r12");
    idle();

    // Random control words, memory data and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rc = ctrl_t'($urandom);
      step(rc, $urandom, ($urandom_range(0, 63) == 0));
    end
    idle();

    guard = 0;
    while ((sb.size() > 0 || dq.size() > 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb.size() > 0 || dq.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size() + dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
